// File: rtl/usb_ulpi_packet_tx.sv
// ULPI link-side transmit engine: TXCMD, payload with appended CRC16, or a bare
// handshake PID, paced by USB_NXT; handles PHY bus turnaround and payload underrun.
module usb_ulpi_packet_tx #(
  parameter int LEN_W = 10
) (
  input  logic             USB_CLKIN,
  input  logic             RST,
  input  logic             USB_DIR,
  input  logic             USB_NXT,
  output logic [7:0]       USB_DATA_O,
  output logic             USB_STP,
  input  logic             start_i,
  input  logic [3:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             tx_busy_o,
  output logic             tx_done_o,
  output logic             tx_abort_o,
  output logic             tx_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXCMD,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_STOP,
    S_UNDERRUN
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             stp_q, stp_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             is_data_q, is_data_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  // Reflected USB CRC16 (0xA001), one byte per call, LSB of the byte first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    data_ready_o = USB_NXT & ~USB_DIR & is_data_q & (cnt_q != '0) &
                   ((state_q == S_TXCMD) | (state_q == S_DATA));

    state_d   = state_q;
    data_d    = data_q;
    stp_d     = 1'b0;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    is_data_d = is_data_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    err_d     = 1'b0;

    // PHY turnaround wins over everything else once a packet is under way.
    if ((state_q != S_IDLE) && USB_DIR) begin
      state_d = S_IDLE;
      data_d  = 8'h00;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_d = 8'h00;
          if (start_i && !USB_DIR) begin
            is_data_d = (pid_i[1:0] == 2'b11);
            cnt_d     = (pid_i[1:0] == 2'b11) ? len_i : '0;
            crc_d     = 16'hFFFF;
            data_d    = {4'b0100, pid_i};
            state_d   = S_TXCMD;
          end
        end
        S_TXCMD, S_DATA: begin
          if (USB_NXT) begin
            if (data_ready_o && !data_valid_i) begin
              data_d  = 8'hFF;
              stp_d   = 1'b1;
              state_d = S_UNDERRUN;
            end else if (!is_data_q) begin
              data_d  = 8'h00;
              stp_d   = 1'b1;
              state_d = S_STOP;
            end else if (cnt_q != '0) begin
              data_d  = data_i;
              crc_d   = crc16_byte(crc_q, data_i);
              cnt_d   = cnt_q - LEN_W'(1);
              state_d = S_DATA;
            end else begin
              data_d  = ~crc_q[7:0];
              state_d = S_CRC_LO;
            end
          end
        end
        S_CRC_LO: begin
          if (USB_NXT) begin
            data_d  = ~crc_q[15:8];
            state_d = S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (USB_NXT) begin
            data_d  = 8'h00;
            stp_d   = 1'b1;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          data_d  = 8'h00;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        S_UNDERRUN: begin
          data_d  = 8'h00;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          data_d  = 8'h00;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge USB_CLKIN) begin
    if (RST) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      stp_q     <= 1'b0;
      crc_q     <= 16'hFFFF;
      cnt_q     <= '0;
      is_data_q <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      stp_q     <= stp_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      is_data_q <= is_data_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  assign USB_DATA_O = data_q;
  assign USB_STP    = stp_q;
  assign tx_busy_o  = (state_q != S_IDLE) | USB_DIR;
  assign tx_done_o  = done_q;
  assign tx_abort_o = abort_q;
  assign tx_err_o   = err_q;

endmodule

// File: tb/tb_usb_ulpi_packet_tx.sv
// Bench for usb_ulpi_packet_tx: directed scenarios plus randomized packets
// checked against a bit-serial CRC16 packet model.
module tb_usb_ulpi_packet_tx;
  localparam int LEN_W = 10;

  typedef logic [7:0] bq_t[$];

  logic             clk;
  logic             RST;
  logic             USB_DIR;
  logic             USB_NXT;
  logic [7:0]       USB_DATA_O;
  logic             USB_STP;
  logic             start_i;
  logic [3:0]       pid_i;
  logic [LEN_W-1:0] len_i;
  logic [7:0]       data_i;
  logic             data_valid_i;
  logic             data_ready_o;
  logic             tx_busy_o;
  logic             tx_done_o;
  logic             tx_abort_o;
  logic             tx_err_o;

  usb_ulpi_packet_tx #(.LEN_W(LEN_W)) dut (
    .USB_CLKIN   (clk),
    .RST         (RST),
    .USB_DIR     (USB_DIR),
    .USB_NXT     (USB_NXT),
    .USB_DATA_O  (USB_DATA_O),
    .USB_STP     (USB_STP),
    .start_i     (start_i),
    .pid_i       (pid_i),
    .len_i       (len_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .tx_busy_o   (tx_busy_o),
    .tx_done_o   (tx_done_o),
    .tx_abort_o  (tx_abort_o),
    .tx_err_o    (tx_err_o)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pay [0:1023];

  // Observations of the most recent run_packet call.
  bq_t        obs_q;
  int         hold_q[$];
  int         stp_cnt, done_cnt, abort_cnt, err_cnt, ready_cnt, bus_cyc;
  logic [7:0] stp_val, end_data, first_byte;
  logic       end_busy;
  bit         timeout;

  // Packet as it must appear on the bus: TXCMD, payload, then the complemented
  // CRC low byte first. CRC computed MSB-first on the bit-serial stream and
  // bit-reversed at the end.
  function automatic bq_t model_stream(input logic [3:0] pid, input int len);
    bq_t         q;
    logic [15:0] r;
    logic [15:0] rf;
    logic        fb;
    q.push_back({4'b0100, pid});
    if (pid[1:0] == 2'b11) begin
      r = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
        q.push_back(pay[i]);
        for (int b = 0; b < 8; b++) begin
          fb = r[15] ^ pay[i][b];
          r  = {r[14:0], 1'b0};
          if (fb) r = r ^ 16'h8005;
        end
      end
      for (int b = 0; b < 16; b++) rf[b] = r[15-b];
      rf = ~rf;
      q.push_back(rf[7:0]);
      q.push_back(rf[15:8]);
    end
    return q;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic idle(input int n);
    USB_NXT = 1'b0;
    USB_DIR = 1'b0;
    start_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one packet and records what the PHY side sees. stall_idx/stall_cyc hold
  // NXT low on a given bus byte; dir_idx raises DIR on a given bus byte; under_idx
  // withholds data_valid_i for that payload byte.
  task automatic run_packet(input logic [3:0] pid, input int len, input int stall_idx,
                            input int stall_cyc, input bit nxt_rand, input int dir_idx,
                            input int under_idx);
    int pidx, cur_hold, stall_left, budget;
    bit ended;
    obs_q.delete();
    hold_q.delete();
    stp_cnt = 0; done_cnt = 0; abort_cnt = 0; err_cnt = 0; ready_cnt = 0; bus_cyc = 0;
    stp_val = 8'h00; end_data = 8'h00; end_busy = 1'b0; timeout = 1'b0;
    pidx = 0; cur_hold = 0; stall_left = stall_cyc; ended = 1'b0;
    budget = 8 * len + 64;
    USB_DIR = 1'b0;
    USB_NXT = 1'b0;
    start_i = 1'b1;
    pid_i   = pid;
    len_i   = len[LEN_W-1:0];
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    first_byte = USB_DATA_O;
    for (int c = 0; c < budget; c++) begin
      if (tx_done_o || tx_abort_o || tx_err_o) begin
        USB_DIR = 1'b0;
        USB_NXT = 1'b0;
        #1;
        done_cnt  = int'(tx_done_o);
        abort_cnt = int'(tx_abort_o);
        err_cnt   = int'(tx_err_o);
        end_data  = USB_DATA_O;
        end_busy  = tx_busy_o;
        ended     = 1'b1;
        break;
      end
      USB_DIR = (dir_idx >= 0) && (obs_q.size() == dir_idx);
      if ((stall_idx == obs_q.size()) && (stall_left > 0)) begin
        USB_NXT = 1'b0;
        stall_left--;
      end else begin
        USB_NXT = nxt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      data_i       = pay[pidx];
      data_valid_i = (pidx != under_idx);
      #1;
      bus_cyc++;
      if (USB_STP) begin
        stp_cnt++;
        stp_val = USB_DATA_O;
      end else begin
        cur_hold++;
        if (USB_NXT && !USB_DIR) begin
          obs_q.push_back(USB_DATA_O);
          hold_q.push_back(cur_hold);
          cur_hold = 0;
        end
      end
      if (data_ready_o) ready_cnt++;
      if (data_ready_o && data_valid_i) pidx++;
      @(posedge clk);
      #1;
    end
    if (!ended) timeout = 1'b1;
    data_valid_i = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; USB_DIR = 1'b0; USB_NXT = 1'b1; start_i = 1'b0;
    pid_i = 4'h3; len_i = '0; data_i = 8'h00; data_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (USB_DATA_O !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", USB_DATA_O); end
    total++; if (USB_STP !== 1'b0) begin bad++; $display("FAIL reset_stp: got %b want 0", USB_STP); end
    total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", data_ready_o); end
    total++; if (tx_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy_o); end
    total++; if ({tx_done_o, tx_abort_o, tx_err_o} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b want 000", {tx_done_o, tx_abort_o, tx_err_o});
    end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_ack();
    bq_t exp;
    exp = model_stream(4'h2, 0);
    run_packet(4'h2, 0, 0, 1, 1'b0, -1, -1);
    total++; if (first_byte !== 8'h42) begin bad++; $display("FAIL ack_txcmd: got %h want 42", first_byte); end
    total++; if (first_diff(obs_q, exp) != -1) begin
      bad++; $display("FAIL ack_bytes: got %p want %p", obs_q, exp);
    end
    total++; if (hold_q.size() < 1 || hold_q[0] != 2) begin
      bad++; $display("FAIL ack_hold: got %p want first=2", hold_q);
    end
    total++; if (stp_cnt != 1 || stp_val !== 8'h00) begin
      bad++; $display("FAIL ack_stp: got cnt=%0d val=%h want cnt=1 val=00", stp_cnt, stp_val);
    end
    total++; if (done_cnt != 1 || end_busy !== 1'b0 || timeout) begin
      bad++; $display("FAIL ack_done: got done=%0d busy=%b timeout=%0d want 1 0 0", done_cnt, end_busy, timeout);
    end
    idle(2);
  endtask

  task automatic fill_ascii();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
  endtask

  task automatic test_data1();
    bq_t exp;
    fill_ascii();
    exp = model_stream(4'hB, 9);
    run_packet(4'hB, 9, -1, 0, 1'b0, -1, -1);
    total++; if (first_diff(obs_q, exp) != -1) begin
      bad++; $display("FAIL data1_bytes: got %p want %p", obs_q, exp);
    end
    total++; if (obs_q.size() != 12 || obs_q[10] !== 8'hC8 || obs_q[11] !== 8'hB4) begin
      bad++; $display("FAIL data1_crc: got %p want ... c8 b4", obs_q);
    end
    total++; if (bus_cyc != 13) begin bad++; $display("FAIL data1_cycles: got %0d want 13", bus_cyc); end
    total++; if (stp_cnt != 1 || done_cnt != 1 || timeout) begin
      bad++; $display("FAIL data1_end: got stp=%0d done=%0d timeout=%0d want 1 1 0", stp_cnt, done_cnt, timeout);
    end
    idle(2);
  endtask

  task automatic test_zlp();
    run_packet(4'h3, 0, -1, 0, 1'b0, -1, -1);
    total++; if (obs_q.size() != 3 || obs_q[0] !== 8'h43 || obs_q[1] !== 8'h00 || obs_q[2] !== 8'h00) begin
      bad++; $display("FAIL zlp_bytes: got %p want 43 00 00", obs_q);
    end
    total++; if (ready_cnt != 0) begin bad++; $display("FAIL zlp_ready: got %0d want 0", ready_cnt); end
    total++; if (bus_cyc != 4 || stp_cnt != 1 || done_cnt != 1) begin
      bad++; $display("FAIL zlp_end: got cyc=%0d stp=%0d done=%0d want 4 1 1", bus_cyc, stp_cnt, done_cnt);
    end
    idle(2);
  endtask

  task automatic test_throttle();
    bq_t exp;
    fill_ascii();
    exp = model_stream(4'hB, 9);
    run_packet(4'hB, 9, 4, 3, 1'b0, -1, -1);
    total++; if (first_diff(obs_q, exp) != -1 || obs_q[10] !== 8'hC8 || obs_q[11] !== 8'hB4) begin
      bad++; $display("FAIL thr_bytes: got %p want %p", obs_q, exp);
    end
    total++; if (hold_q.size() < 5 || hold_q[4] != 4 || obs_q[4] !== 8'h34) begin
      bad++; $display("FAIL thr_hold: got holds %p want 4 cycles on byte 34", hold_q);
    end
    total++; if (done_cnt != 1 || stp_cnt != 1) begin
      bad++; $display("FAIL thr_end: got done=%0d stp=%0d want 1 1", done_cnt, stp_cnt);
    end
    idle(2);
  endtask

  task automatic test_abort();
    fill_ascii();
    run_packet(4'hB, 9, -1, 0, 1'b0, 5, -1);
    total++; if (abort_cnt != 1 || done_cnt != 0 || timeout) begin
      bad++; $display("FAIL abort_pulse: got abort=%0d done=%0d timeout=%0d want 1 0 0", abort_cnt, done_cnt, timeout);
    end
    total++; if (stp_cnt != 0 || end_data !== 8'h00) begin
      bad++; $display("FAIL abort_bus: got stp=%0d data=%h want 0 00", stp_cnt, end_data);
    end
    total++; if (obs_q.size() != 5 || end_busy !== 1'b0) begin
      bad++; $display("FAIL abort_len: got %0d bytes busy=%b want 5 0", obs_q.size(), end_busy);
    end
    idle(2);
  endtask

  task automatic test_underrun();
    bq_t exp;
    fill_ascii();
    exp = model_stream(4'hB, 9);
    while (exp.size() > 4) void'(exp.pop_back());
    run_packet(4'hB, 9, -1, 0, 1'b0, -1, 3);
    total++; if (stp_cnt != 1 || stp_val !== 8'hFF) begin
      bad++; $display("FAIL under_stp: got cnt=%0d val=%h want 1 ff", stp_cnt, stp_val);
    end
    total++; if (err_cnt != 1 || done_cnt != 0 || end_busy !== 1'b0) begin
      bad++; $display("FAIL under_err: got err=%0d done=%0d busy=%b want 1 0 0", err_cnt, done_cnt, end_busy);
    end
    total++; if (first_diff(obs_q, exp) != -1) begin
      bad++; $display("FAIL under_bytes: got %p want %p", obs_q, exp);
    end
    exp = model_stream(4'h2, 0);
    run_packet(4'h2, 0, -1, 0, 1'b0, -1, -1);
    total++; if (first_diff(obs_q, exp) != -1 || done_cnt != 1 || stp_cnt != 1) begin
      bad++; $display("FAIL under_ack: got %p done=%0d stp=%0d want 42 1 1", obs_q, done_cnt, stp_cnt);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    bq_t exp;
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    run_packet(4'h3, 6, -1, 0, 1'b0, -1, -1);
    total++; if (done_cnt != 1 || end_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got done=%0d busy=%b want 1 0", done_cnt, end_busy);
    end
    exp = model_stream(4'hA, 0);
    run_packet(4'hA, 0, -1, 0, 1'b0, -1, -1);
    total++; if (first_byte !== 8'h4A || first_diff(obs_q, exp) != -1 || done_cnt != 1) begin
      bad++; $display("FAIL b2b_second: got first=%h %p done=%0d want 4a", first_byte, obs_q, done_cnt);
    end
    idle(2);
  endtask

  task automatic test_start_ignored();
    USB_DIR = 1'b1; start_i = 1'b1; pid_i = 4'h2;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    total++; if (tx_busy_o !== 1'b1 || USB_DATA_O !== 8'h00) begin
      bad++; $display("FAIL dir_busy: got busy=%b data=%h want 1 00", tx_busy_o, USB_DATA_O);
    end
    USB_DIR = 1'b0;
    @(posedge clk);
    #1;
    total++; if (tx_busy_o !== 1'b0 || USB_DATA_O !== 8'h00) begin
      bad++; $display("FAIL dir_ignored: got busy=%b data=%h want 0 00", tx_busy_o, USB_DATA_O);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    USB_DIR = 1'b0; USB_NXT = 1'b1; data_valid_i = 1'b1; data_i = pay[0];
    start_i = 1'b1; pid_i = 4'hB; len_i = 10'd20;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    total++; if (tx_busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got %b want 1", tx_busy_o); end
    RST = 1'b1;
    @(posedge clk);
    #1;
    total++; if (USB_DATA_O !== 8'h00 || USB_STP !== 1'b0 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: got data=%h stp=%b busy=%b done=%b want 00 0 0 0",
                      USB_DATA_O, USB_STP, tx_busy_o, tx_done_o);
    end
    RST = 1'b0;
    @(posedge clk);
    #1;
    total++; if (USB_STP !== 1'b0 || tx_busy_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got stp=%b busy=%b want 0 0", USB_STP, tx_busy_o);
    end
    idle(2);
  endtask

  task automatic test_random();
    bq_t        exp;
    logic [3:0] pid;
    int         len;
    for (int n = 0; n < 24; n++) begin
      pid = 4'($urandom);
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      exp = model_stream(pid, len);
      run_packet(pid, len, -1, 0, 1'b1, -1, -1);
      total++; if (first_diff(obs_q, exp) != -1) begin
        bad++; $display("FAIL rand_bytes[%0d] pid=%h len=%0d: got %p want %p", n, pid, len, obs_q, exp);
      end
      total++; if (stp_cnt != 1 || stp_val !== 8'h00 || done_cnt != 1 || timeout) begin
        bad++; $display("FAIL rand_end[%0d]: got stp=%0d val=%h done=%0d timeout=%0d want 1 00 1 0",
                        n, stp_cnt, stp_val, done_cnt, timeout);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data1();
    test_zlp();
    test_throttle();
    test_abort();
    test_underrun();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_ulpi_packet_tx.md
# usb_ulpi_packet_tx

Link-side ULPI transmit engine: sends one USB packet (handshake or DATA0/DATA1) through the PHY's ULPI port using a TXCMD, paced by USB_NXT. Data packets get their CRC16 generated and appended here. Handshake packets (ACK/NAK/STALL) are sent as a bare PID. Sits beside the ULPI receive path in the USB top level. It is the outbound counterpart to the token/data extraction path; the top level muxes USB_DATA_O onto the shared USB_DATA bus while USB_DIR=0.

## Interface
- LEN_W, 10, width of payload length; max payload 2^LEN_W-1 bytes
- USB_CLKIN  in  1  60 MHz ULPI clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- USB_DIR  in  1  PHY bus ownership; 1 = PHY drives bus
- USB_NXT  in  1  PHY accepts the byte currently on USB_DATA_O
- USB_DATA_O  out  8  registered link-driven ULPI data
- USB_STP  out  1  registered stop strobe
- start_i  in  1  request to send one packet
- pid_i  in  4  USB PID; pid_i[1:0]==2'b11 means a data packet, anything else means a handshake with no payload
- len_i  in  LEN_W  payload bytes; ignored for handshakes; 0 = zero-length packet
- data_i  in  8  payload byte
- data_valid_i  in  1  data_i valid
- data_ready_o  out  1  combinational; the byte is consumed when data_valid_i & data_ready_o
- tx_busy_o  out  1  packet in progress, or USB_DIR=1
- tx_done_o  out  1  one-cycle pulse: packet completed
- tx_abort_o  out  1  one-cycle pulse: PHY took the bus mid-packet
- tx_err_o  out  1  one-cycle pulse: payload underrun

## Operation
- States: IDLE, TXCMD, DATA, CRC_LO, CRC_HI, STOP, UNDERRUN.
- **IDLE**
  - USB_DATA_O=0x00, USB_STP=0.
  - start_i is accepted only when IDLE and USB_DIR=0; otherwise it is ignored and the caller retries on !tx_busy_o.
  - On accept: latch pid and len, set CRC=0xFFFF, load USB_DATA_O={4'b0100,pid}, go to TXCMD.
- **TXCMD**
  - Hold the byte while NXT=0.
  - On NXT=1, handshake packet: load 0x00, go to STOP.
  - On NXT=1, data packet with len>0: pop byte 0 into USB_DATA_O, update CRC, set cnt=len-1, go to DATA.
  - On NXT=1, data packet with len=0: load ~CRC[7:0], go to CRC_LO.
- **DATA**
  - Hold the byte while NXT=0.
  - On NXT=1 with cnt≠0: pop the next byte, update CRC, decrement cnt.
  - On NXT=1 with cnt=0: load ~CRC[7:0], go to CRC_LO.
- **CRC_LO**: on NXT=1, load ~CRC[15:8], go to CRC_HI.
- **CRC_HI**: on NXT=1, go to STOP.
- **STOP**: USB_DATA_O=0x00, USB_STP=1 for exactly one cycle, then IDLE with tx_done_o=1.
- **data_ready_o** = USB_NXT & ~USB_DIR & data packet & cnt-remaining≠0 & state∈{TXCMD,DATA}.
- **CRC16**: USB CRC16, polynomial 0x8005 processed LSB-first (reflected constant 0xA001), init 0xFFFF, one byte per cycle. The complemented CRC is sent low byte first.
- **Underrun**: if data_ready_o=1 and data_valid_i=0, go to UNDERRUN.
  - Drive USB_DATA_O=0xFF with USB_STP=1 for one cycle. This makes the PHY emit a bit-stuff error so the host discards the packet.
  - Then IDLE with tx_err_o=1.
- **Abort**: USB_DIR=1 sampled in any non-IDLE state goes to IDLE on the next edge.
  - USB_DATA_O=0x00, no STP, tx_abort_o=1.
  - Abort takes precedence over NXT and underrun in the same cycle.
- **Reset**: RST=1 mid-packet goes to IDLE immediately without STP.

## Timing
- Reset values: USB_DATA_O=0x00, USB_STP=0, data_ready_o=0, tx_busy_o=0, tx_done_o=0, tx_abort_o=0, tx_err_o=0, CRC=0xFFFF, cnt=0.
- start_i accepted at edge N: TXCMD is on USB_DATA_O from cycle N+1.
- Each byte is replaced on the edge where NXT=1; with NXT held high, one byte per cycle.
- Minimum packet lengths:
  - Handshake: TXCMD + STOP = 2 bus cycles.
  - Data packet: len+4 cycles.
- tx_done_o is asserted in the cycle after STP; tx_busy_o drops the same cycle. A new start_i is accepted in that cycle if USB_DIR=0.
- No byte is popped and the CRC is not updated on cycles with NXT=0.

## Test plan
- **ACK**: start, pid 0x2, NXT=1 on the second cycle → 0x42 held until NXT, then 0x00 with STP=1 for one cycle, then a tx_done_o pulse.
- **DATA1 payload**: pid 0xB, len 9, payload 0x31..0x39, NXT always 1 → bus sequence 0x4B, 0x31..0x39, 0xC8, 0xB4, then STP.
- **Zero-length DATA0**: pid 0x3, len 0 → 0x43, 0x00, 0x00, STP; data_ready_o never asserted.
- **Throttling**: same as the DATA1 case but NXT=0 for 3 cycles after byte 0x34 → 0x34 held 4 cycles; CRC bytes still 0xC8, 0xB4.
- **Abort**: USB_DIR=1 while byte 5 is on the bus → IDLE next edge, USB_DATA_O=0x00, STP never asserted, tx_abort_o pulse, no tx_done_o.
- **Underrun**: data_valid_i=0 when byte 3 is requested → one cycle of 0xFF with STP=1, tx_err_o pulse, then IDLE; a following ACK sends normally.
